lsram_req_arbiter: RTL and testbench
====================================

// Module: lsram_req_arbiter
// PURPOSE
//  2-port arbiter sharing the LSRAM SRAM-control request interface (req/write/size/addr/wdata -> ack/rdata).
//  Port 0 = AHB-Lite slave path, port 1 = UART/SPI boot-loader write path. Serialises one access at a time.
//  Registers the granted command, issues one req pulse, waits for ack, and returns ack and rdata to the owner.
// PARAMETERS
//  MEM_AWIDTH   19  byte-address width of mX_addr / ahbsram_addr
//  ARB_MODE     0   0 = round-robin; 1 = fixed priority, port 0 preferred
//  MAX_CONSEC   8   fixed mode only: max consecutive port-0 grants while port 1 waits (1..255)
// PORTS
//  HCLK          in   1            clock
//  aresetn       in   1            asynchronous, active-low reset
//  mX_req        in   1            X=0,1; level request, held until mX_ack
//  mX_write      in   1            1 = write, 0 = read
//  mX_size       in   3            AHB HSIZE: 000 = byte, 001 = half, 010 = word
//  mX_addr       in   MEM_AWIDTH   byte address
//  mX_wdata      in   32           write data
//  mX_ack        out  1            1-cycle completion pulse
//  mX_rdata      out  32           read data, valid in the mX_ack cycle
//  ahbsram_req   out  1            1-cycle request pulse to the SRAM controller
//  ahbsram_write / _size / _addr / _wdata   out  1 / 3 / MEM_AWIDTH / 32   registered granted command
//  sramahb_ack   in   1            controller completion, combinational 1-cycle pulse
//  sramahb_rdata in   32           controller read data, valid the cycle after sramahb_ack
//  BUSY          in   1            controller busy; blocks new grants
//  gnt           out  2            one-hot current owner; 00 when idle
// BEHAVIOUR
//  Reset (async, aresetn = 0): state IDLE; all outputs 0; command registers 0; last_gnt = 1 (port 0 wins first); consec_cnt = 0.
//  FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   IDLE:  if BUSY = 0 and any mX_req, pick the winner, register its command and gnt -> ISSUE. BUSY = 1: stay, no grant.
//   ISSUE: ahbsram_req = 1 for exactly one cycle -> WAIT.
//   WAIT:  on sramahb_ack -> DONE. No timeout.
//   DONE:  mX_ack = 1 for the owner; mX_rdata = sramahb_rdata (captured into a holding reg); last_gnt = owner -> IDLE.
//  Latency: req seen in IDLE at cycle 0 -> ahbsram_req at cycle 1 -> sramahb_ack at cycle 2 -> mX_ack at cycle 3.
//   Minimum request-to-request spacing per port is 4 cycles.
//  Command registers stay stable from ISSUE through DONE; requester input changes after the grant are ignored.
//  mX_req is ignored in DONE. The requester drops req, or presents a new command, on the edge after mX_ack.
//  mX_rdata holds the last returned value until the next read ack on that port. Writes return the same ack timing.
//  Round-robin: if both ports request, grant !last_gnt; if one requests, grant it.
//  Fixed priority: port 0 wins. consec_cnt increments on each port-0 grant while m1_req = 1.
//   When consec_cnt = MAX_CONSEC, port 1 wins the next arbitration. consec_cnt clears on any port-1 grant or when m1_req = 0.
//  Simultaneous events: a request arriving in ISSUE/WAIT/DONE waits for IDLE. Arbitration uses IDLE-cycle values only.
//  Spurious sramahb_ack in IDLE or ISSUE: ignored, no mX_ack.
//  Reset mid-transfer: abort immediately to reset values. No ack is ever issued for the aborted access.
//  gnt and mX_ack are never both active for two ports at once (assertion).
// STRUCTURE
//  Shared package lsram_arb_pkg: FSM state encodings (2-bit: IDLE = 00, ISSUE = 01, WAIT = 10, DONE = 11),
//   port indices, HSIZE constants.
//  Sub-module lsram_arb_pick: combinational winner select (reqs, last_gnt, ARB_MODE, consec_cnt) -> one-hot pick.
//  Top level holds the FSM, command and rdata registers, and consec_cnt.
// TESTING
//  Single read port 0, addr 0x40, controller model returns 0xDEADBEEF -> req pulse cycle 1, m0_ack cycle 3, m0_rdata = 0xDEADBEEF.
//  Round-robin, m0_req and m1_req held high continuously -> grants alternate 0,1,0,1; first grant port 0 after reset.
//  Fixed, MAX_CONSEC = 2, both ports requesting -> grant order 0,0,1,0,0,1.
//  BUSY = 1 for 5 cycles with m1_req high -> no ahbsram_req until BUSY drops, then normal 3-cycle latency.
//  aresetn low during WAIT -> gnt = 00, no mX_ack; after release a new port-1 write (size 000, addr 0x3) completes.
//  Port-1 write changes m1_wdata after the grant -> ahbsram_wdata holds the value captured in IDLE.

Source files
------------

// File: rtl/lsram_arb_pkg.sv
// Shared definitions for the LSRAM request arbiter: FSM encodings, port indices, HSIZE codes.
// No logic of its own.
// Imported by the arbiter top level and its winner-select sub-module.
package lsram_arb_pkg;

  // Transfer sequencer states; the encoding is visible on debug taps, keep it fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } arb_state_t;

  // Port indices: port 0 is the AHB-Lite slave path, port 1 the boot-loader write path.
  localparam logic PORT_AHB  = 1'b0;
  localparam logic PORT_BOOT = 1'b1;

  // AHB HSIZE encodings passed straight through to the SRAM controller.
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Width of the consecutive port-0 grant counter (MAX_CONSEC is limited to 255).
  localparam int CONSEC_W = 8;

  // Port index to one-hot grant vector.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lsram_arb_pick.sv
// Combinational winner select between the two LSRAM requesters.
// Zero latency; result is only used by the top level in its IDLE cycle.
// No flow control of its own: outputs 00 when nobody is requesting.
module lsram_arb_pick
  import lsram_arb_pkg::*;
#(
  parameter int ARB_MODE   = 0,
  parameter int MAX_CONSEC = 8
) (
  input  logic [1:0]          reqs,
  input  logic                last_gnt,
  input  logic [CONSEC_W-1:0] consec_cnt,
  output logic [1:0]          pick
);

  localparam logic [CONSEC_W-1:0] MAX_C = CONSEC_W'(MAX_CONSEC);

  logic starve;

  // Port 1 has waited out its quota of back-to-back port-0 grants.
  assign starve = (consec_cnt >= MAX_C);

  // Pick the winner: a lone requester always wins; contention goes by the arbitration mode.
  always_comb begin
    pick = reqs;
    if (reqs == 2'b11) begin
      if (ARB_MODE == 1) begin
        pick = starve ? port_onehot(PORT_BOOT) : port_onehot(PORT_AHB);
      end else begin
        pick = port_onehot(~last_gnt);
      end
    end
  end

endmodule

// File: rtl/lsram_req_arbiter.sv
// Two-port arbiter in front of the LSRAM SRAM-control request interface; one access in flight.
// Latency: request seen in IDLE at cycle 0, ahbsram_req at cycle 1, requester ack at cycle 3 (with a 1-cycle controller).
// Backpressure: BUSY holds off new grants; requesters hold their level req until their ack pulse.
module lsram_req_arbiter
  import lsram_arb_pkg::*;
#(
  parameter int MEM_AWIDTH = 19,
  parameter int ARB_MODE   = 0,
  parameter int MAX_CONSEC = 8
) (
  input  logic                  HCLK,
  input  logic                  aresetn,
  // port 0: AHB-Lite slave path
  input  logic                  m0_req,
  input  logic                  m0_write,
  input  logic [2:0]            m0_size,
  input  logic [MEM_AWIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_ack,
  output logic [31:0]           m0_rdata,
  // port 1: boot-loader write path
  input  logic                  m1_req,
  input  logic                  m1_write,
  input  logic [2:0]            m1_size,
  input  logic [MEM_AWIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_ack,
  output logic [31:0]           m1_rdata,
  // SRAM controller side
  output logic                  ahbsram_req,
  output logic                  ahbsram_write,
  output logic [2:0]            ahbsram_size,
  output logic [MEM_AWIDTH-1:0] ahbsram_addr,
  output logic [31:0]           ahbsram_wdata,
  input  logic                  sramahb_ack,
  input  logic [31:0]           sramahb_rdata,
  input  logic                  BUSY,
  output logic [1:0]            gnt
);

  arb_state_t          state;
  logic                owner;
  logic                last_gnt;
  logic [CONSEC_W-1:0] consec_cnt;
  logic [1:0]          reqs;
  logic [1:0]          pick;
  logic                grant_fire;
  logic                sel_write;
  logic [2:0]          sel_size;
  logic [MEM_AWIDTH-1:0] sel_addr;
  logic [31:0]         sel_wdata;
  logic [31:0]         hold0_rdata;
  logic [31:0]         hold1_rdata;
  logic                done_read;

  assign reqs = {m1_req, m0_req};

  lsram_arb_pick #(
    .ARB_MODE   (ARB_MODE),
    .MAX_CONSEC (MAX_CONSEC)
  ) u_pick (
    .reqs       (reqs),
    .last_gnt   (last_gnt),
    .consec_cnt (consec_cnt),
    .pick       (pick)
  );

  // A grant happens only from IDLE, only while the controller is free.
  assign grant_fire = (state == ST_IDLE) && !BUSY && (reqs != 2'b00);

  // Steer the winning requester's command towards the command registers.
  always_comb begin
    sel_write = m0_write;
    sel_size  = m0_size;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (pick[1]) begin
      sel_write = m1_write;
      sel_size  = m1_size;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  // Transfer sequencer: grant, one req pulse, wait for the controller, ack the owner.
  always_ff @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      owner         <= PORT_AHB;
      last_gnt      <= PORT_BOOT;
      gnt           <= 2'b00;
      ahbsram_req   <= 1'b0;
      ahbsram_write <= 1'b0;
      ahbsram_size  <= 3'b000;
      ahbsram_addr  <= '0;
      ahbsram_wdata <= 32'h0;
      m0_ack        <= 1'b0;
      m1_ack        <= 1'b0;
    end else begin
      ahbsram_req <= 1'b0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            owner         <= pick[1];
            gnt           <= pick;
            ahbsram_req   <= 1'b1;
            ahbsram_write <= sel_write;
            ahbsram_size  <= sel_size;
            ahbsram_addr  <= sel_addr;
            ahbsram_wdata <= sel_wdata;
            state         <= ST_ISSUE;
          end
        end
        // The controller cannot answer a request in the cycle it is issued.
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (sramahb_ack) begin
            m0_ack <= (owner == PORT_AHB);
            m1_ack <= (owner == PORT_BOOT);
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          last_gnt <= owner;
          gnt      <= 2'b00;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Count back-to-back port-0 wins while port 1 is kept waiting.
  always_ff @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) begin
      consec_cnt <= '0;
    end else if (!m1_req) begin
      consec_cnt <= '0;
    end else if (grant_fire) begin
      if (pick[1]) begin
        consec_cnt <= '0;
      end else if ((ARB_MODE == 1) && (consec_cnt != '1)) begin
        consec_cnt <= consec_cnt + CONSEC_W'(1);
      end
    end
  end

  // Read data arrives one cycle after the controller ack, i.e. in DONE.
  assign done_read = (state == ST_DONE) && !ahbsram_write;

  // Keep each port's last read value until its next read completes.
  always_ff @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) begin
      hold0_rdata <= 32'h0;
      hold1_rdata <= 32'h0;
    end else if (done_read) begin
      if (owner == PORT_BOOT) hold1_rdata <= sramahb_rdata;
      else                    hold0_rdata <= sramahb_rdata;
    end
  end

  // In the ack cycle the fresh controller data bypasses the holding register.
  always_comb begin
    m0_rdata = hold0_rdata;
    m1_rdata = hold1_rdata;
    if (done_read && (owner == PORT_AHB))  m0_rdata = sramahb_rdata;
    if (done_read && (owner == PORT_BOOT)) m1_rdata = sramahb_rdata;
  end

  // Ownership and completion are exclusive between the two ports.
  a_single_owner: assert property (@(posedge HCLK) disable iff (!aresetn)
    $onehot0(gnt) && !(m0_ack && m1_ack));

endmodule

// File: tb/tb_lsram_req_arbiter.sv
module tb_lsram_req_arbiter;
  import lsram_arb_pkg::*;

  logic        HCLK;
  logic        aresetn;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [2:0]  m0_size, m1_size;
  logic [18:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ahbsram_req, ahbsram_write;
  logic [2:0]  ahbsram_size;
  logic [18:0] ahbsram_addr;
  logic [31:0] ahbsram_wdata;
  logic        sramahb_ack;
  logic [31:0] sramahb_rdata;
  logic        BUSY;
  logic [1:0]  gnt;

  // fixed-priority instance (MAX_CONSEC = 2), sharing the requester inputs
  logic        f_m0_ack, f_m1_ack, f_req, f_write, f_ack;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_wdata, f_rdata;
  logic [2:0]  f_size;
  logic [18:0] f_addr;
  logic [1:0]  f_gnt;

  int          errors = 0;
  int          checks = 0;
  int          ctrl_delay;
  logic [31:0] ctrl_rdata;
  logic        spur;

  lsram_req_arbiter #(.MEM_AWIDTH(19), .ARB_MODE(0), .MAX_CONSEC(8)) dut (
    .HCLK(HCLK), .aresetn(aresetn),
    .m0_req(m0_req), .m0_write(m0_write), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ahbsram_req(ahbsram_req), .ahbsram_write(ahbsram_write), .ahbsram_size(ahbsram_size),
    .ahbsram_addr(ahbsram_addr), .ahbsram_wdata(ahbsram_wdata),
    .sramahb_ack(sramahb_ack), .sramahb_rdata(sramahb_rdata), .BUSY(BUSY), .gnt(gnt)
  );

  lsram_req_arbiter #(.MEM_AWIDTH(19), .ARB_MODE(1), .MAX_CONSEC(2)) dut_fixed (
    .HCLK(HCLK), .aresetn(aresetn),
    .m0_req(m0_req), .m0_write(m0_write), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(f_m0_ack), .m0_rdata(f_m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(f_m1_ack), .m1_rdata(f_m1_rdata),
    .ahbsram_req(f_req), .ahbsram_write(f_write), .ahbsram_size(f_size),
    .ahbsram_addr(f_addr), .ahbsram_wdata(f_wdata),
    .sramahb_ack(f_ack), .sramahb_rdata(f_rdata), .BUSY(BUSY), .gnt(f_gnt)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // SRAM controller model: ack ctrl_delay+1 cycles after the req pulse, data one cycle after ack.
  initial begin : ctrl_model
    int   cnt;
    logic give;
    cnt = 0; give = 1'b0;
    sramahb_ack = 1'b0; sramahb_rdata = 32'h0;
    forever begin
      @(posedge HCLK); #2;
      sramahb_ack   = spur;
      sramahb_rdata = give ? ctrl_rdata : 32'h0;
      give = 1'b0;
      if (!aresetn) cnt = 0;
      else if (cnt == 1) begin sramahb_ack = 1'b1; give = 1'b1; cnt = 0; end
      else if (cnt > 1) cnt = cnt - 1;
      if (ahbsram_req) cnt = ctrl_delay + 1;
    end
  end

  // Minimal 1-cycle controller for the fixed-priority instance.
  initial begin : ctrl_model_fixed
    logic fire, give;
    fire = 1'b0; give = 1'b0; f_ack = 1'b0; f_rdata = 32'h0;
    forever begin
      @(posedge HCLK); #2;
      f_ack   = fire && aresetn;
      f_rdata = give ? 32'hF00D0000 : 32'h0;
      give    = f_ack;
      fire    = f_req;
    end
  end

  task automatic step();
    @(posedge HCLK); #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0; m0_req = 1'b0; m1_req = 1'b0; BUSY = 1'b0; spur = 1'b0; ctrl_delay = 0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK); aresetn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    aresetn = 1'b0; m0_req = 1'b1; m1_req = 1'b1; BUSY = 1'b0;
    repeat (2) @(negedge HCLK);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b expected 00", gnt); end
    checks++; if (ahbsram_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", ahbsram_req); end
    checks++; if ({m0_ack, m1_ack} !== 2'b00) begin errors++; $display("FAIL rst_ack: got %b expected 00", {m0_ack, m1_ack}); end
    checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h/%h expected 0/0", m0_rdata, m1_rdata); end
    checks++; if ({ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata} !== 55'h0) begin errors++; $display("FAIL rst_cmd: got %h/%h/%h expected 0", ahbsram_size, ahbsram_addr, ahbsram_wdata); end
  endtask

  task automatic test_single_read();
    do_reset(); ctrl_rdata = 32'hDEADBEEF;
    m0_req = 1'b1; m0_write = 1'b0; m0_size = HSIZE_WORD; m0_addr = 19'h40;        // cycle 0
    @(negedge HCLK);
    checks++; if (ahbsram_req !== 1'b0) begin errors++; $display("FAIL rd_c0_req: got %b expected 0", ahbsram_req); end
    step(); @(negedge HCLK);                                                         // cycle 1
    checks++; if (ahbsram_req !== 1'b1) begin errors++; $display("FAIL rd_c1_req: got %b expected 1", ahbsram_req); end
    checks++; if (gnt !== 2'b01 || ahbsram_addr !== 19'h40 || ahbsram_write !== 1'b0) begin errors++; $display("FAIL rd_c1_cmd: got gnt %b addr %h wr %b expected 01 00040 0", gnt, ahbsram_addr, ahbsram_write); end
    step(); @(negedge HCLK);                                                         // cycle 2
    checks++; if (ahbsram_req !== 1'b0 || m0_ack !== 1'b0) begin errors++; $display("FAIL rd_c2: got req %b ack %b expected 0 0", ahbsram_req, m0_ack); end
    step(); @(negedge HCLK);                                                         // cycle 3
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL rd_c3_ack: got %b%b expected m0=1 m1=0", m0_ack, m1_ack); end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_c3_rdata: got %h expected deadbeef", m0_rdata); end
    step();                                                                          // cycle 4: new write command
    m0_write = 1'b1; m0_size = HSIZE_BYTE; m0_addr = 19'h41; m0_wdata = 32'h000000AA; ctrl_rdata = 32'h12345678;
    @(negedge HCLK);
    checks++; if (m0_ack !== 1'b0 || gnt !== 2'b00 || m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_c4_idle: got ack %b gnt %b rdata %h expected 0 00 deadbeef", m0_ack, gnt, m0_rdata); end
    step(); step(); step(); @(negedge HCLK);                                         // cycle 7: write ack
    checks++; if (m0_ack !== 1'b1 || ahbsram_write !== 1'b1) begin errors++; $display("FAIL wr_ack: got ack %b wr %b expected 1 1", m0_ack, ahbsram_write); end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rdata_hold: got %h expected deadbeef", m0_rdata); end
    step(); m0_req = 1'b0;
    @(negedge HCLK);
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold_after: got %h expected deadbeef", m0_rdata); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  seen_gnt [6];
    logic [18:0] seen_addr [6];
    logic [1:0]  exp_gnt;
    logic [18:0] exp_addr;
    int n;
    do_reset(); ctrl_rdata = 32'h0;
    m0_req = 1'b1; m0_write = 1'b0; m0_size = HSIZE_WORD; m0_addr = 19'h100;
    m1_req = 1'b1; m1_write = 1'b1; m1_size = HSIZE_WORD; m1_addr = 19'h200; m1_wdata = 32'hCAFE0001;
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge HCLK);
      if (ahbsram_req === 1'b1 && n < 4) begin seen_gnt[n] = gnt; seen_addr[n] = ahbsram_addr; n++; end
      if (f_req === 1'b1 && n >= 4) begin end
      step();
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_count: got %0d grants expected 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      exp_gnt  = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (i % 2 == 0) ? 19'h100 : 19'h200;
      checks++; if (seen_gnt[i] !== exp_gnt || seen_addr[i] !== exp_addr) begin errors++; $display("FAIL rr_grant%0d: got %b addr %h expected %b addr %h", i, seen_gnt[i], seen_addr[i], exp_gnt, exp_addr); end
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_fixed_priority();
    logic [1:0] seen [6];
    logic [1:0] expv [6];
    int n;
    expv[0] = 2'b01; expv[1] = 2'b01; expv[2] = 2'b10;
    expv[3] = 2'b01; expv[4] = 2'b01; expv[5] = 2'b10;
    do_reset();
    m0_req = 1'b1; m0_write = 1'b0; m0_addr = 19'h300;
    m1_req = 1'b1; m1_write = 1'b1; m1_addr = 19'h400;
    n = 0;
    for (int c = 0; c < 80 && n < 6; c++) begin
      @(negedge HCLK);
      if (f_req === 1'b1) begin seen[n] = f_gnt; n++; end
      step();
    end
    checks++; if (n !== 6) begin errors++; $display("FAIL fx_count: got %0d grants expected 6", n); end
    for (int i = 0; i < 6 && i < n; i++) begin
      checks++; if (seen[i] !== expv[i]) begin errors++; $display("FAIL fx_grant%0d: got %b expected %b", i, seen[i], expv[i]); end
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_busy();
    logic busy_ok;
    do_reset();
    BUSY = 1'b1; m1_req = 1'b1; m1_write = 1'b1; m1_size = HSIZE_HALF; m1_addr = 19'h7FFFE; m1_wdata = 32'h0000BEEF;
    busy_ok = 1'b1;
    repeat (5) begin
      @(negedge HCLK);
      if (ahbsram_req !== 1'b0 || gnt !== 2'b00) busy_ok = 1'b0;
      step();
    end
    checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL busy_block: got grant while BUSY expected none"); end
    BUSY = 1'b0;                                                                     // cycle 0
    @(negedge HCLK);
    checks++; if (ahbsram_req !== 1'b0) begin errors++; $display("FAIL busy_c0: got %b expected 0", ahbsram_req); end
    step(); @(negedge HCLK);
    checks++; if (ahbsram_req !== 1'b1 || gnt !== 2'b10 || ahbsram_addr !== 19'h7FFFE || ahbsram_size !== HSIZE_HALF) begin errors++; $display("FAIL busy_c1: got req %b gnt %b addr %h size %b expected 1 10 7fffe 001", ahbsram_req, gnt, ahbsram_addr, ahbsram_size); end
    step(); step(); @(negedge HCLK);
    checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("FAIL busy_c3_ack: got m1 %b m0 %b expected 1 0", m1_ack, m0_ack); end
    step(); m1_req = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic quiet;
    do_reset(); ctrl_delay = 5;
    m0_req = 1'b1; m0_write = 1'b0; m0_size = HSIZE_WORD; m0_addr = 19'h80;        // cycle 0
    step(); @(negedge HCLK);                                                         // cycle 1
    checks++; if (ahbsram_req !== 1'b1) begin errors++; $display("FAIL rw_issue: got %b expected 1", ahbsram_req); end
    step(); @(negedge HCLK);                                                         // cycle 2: WAIT
    aresetn = 1'b0; #1;
    checks++; if (gnt !== 2'b00 || ahbsram_addr !== 19'h0 || m0_ack !== 1'b0) begin errors++; $display("FAIL rw_abort: got gnt %b addr %h ack %b expected 00 0 0", gnt, ahbsram_addr, m0_ack); end
    m0_req = 1'b0;
    quiet = 1'b1;
    repeat (2) begin @(negedge HCLK); if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || gnt !== 2'b00) quiet = 1'b0; end
    aresetn = 1'b1; ctrl_delay = 0;
    repeat (6) begin step(); @(negedge HCLK); if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || gnt !== 2'b00) quiet = 1'b0; end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL rw_no_ack: got ack or grant for aborted access expected none"); end
    step();
    m1_req = 1'b1; m1_write = 1'b1; m1_size = HSIZE_BYTE; m1_addr = 19'h3; m1_wdata = 32'h000000A5;   // cycle 0
    step(); @(negedge HCLK);
    checks++; if (ahbsram_req !== 1'b1 || gnt !== 2'b10 || ahbsram_write !== 1'b1 || ahbsram_size !== 3'b000 || ahbsram_addr !== 19'h3 || ahbsram_wdata !== 32'hA5) begin errors++; $display("FAIL rw_new_cmd: got req %b gnt %b wr %b size %b addr %h wdata %h expected 1 10 1 000 3 a5", ahbsram_req, gnt, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata); end
    step(); step(); @(negedge HCLK);
    checks++; if (m1_ack !== 1'b1) begin errors++; $display("FAIL rw_new_ack: got %b expected 1", m1_ack); end
    step(); m1_req = 1'b0;
  endtask

  task automatic test_cmd_hold();
    do_reset();
    m1_req = 1'b1; m1_write = 1'b1; m1_size = HSIZE_WORD; m1_addr = 19'h10; m1_wdata = 32'h11111111;   // cycle 0
    step(); m1_wdata = 32'h22222222; m1_addr = 19'h20; m1_write = 1'b0;             // cycle 1
    @(negedge HCLK);
    checks++; if (ahbsram_wdata !== 32'h11111111 || ahbsram_addr !== 19'h10) begin errors++; $display("FAIL hold_c1: got wdata %h addr %h expected 11111111 10", ahbsram_wdata, ahbsram_addr); end
    step(); @(negedge HCLK);
    checks++; if (ahbsram_wdata !== 32'h11111111 || ahbsram_write !== 1'b1) begin errors++; $display("FAIL hold_c2: got wdata %h wr %b expected 11111111 1", ahbsram_wdata, ahbsram_write); end
    step(); @(negedge HCLK);
    checks++; if (m1_ack !== 1'b1 || ahbsram_wdata !== 32'h11111111) begin errors++; $display("FAIL hold_c3: got ack %b wdata %h expected 1 11111111", m1_ack, ahbsram_wdata); end
    step(); m1_req = 1'b0;
  endtask

  task automatic test_spurious_ack();
    do_reset();
    spur = 1'b1;                                                                     // ack with nothing pending
    step(); spur = 1'b0; @(negedge HCLK);
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || gnt !== 2'b00) begin errors++; $display("FAIL sp_idle: got ack %b%b gnt %b expected 00 00", m1_ack, m0_ack, gnt); end
    ctrl_delay = 2; ctrl_rdata = 32'h0BADF00D;
    m0_req = 1'b1; m0_write = 1'b0; m0_size = HSIZE_WORD; m0_addr = 19'h44;        // cycle 0
    step(); spur = 1'b1; @(negedge HCLK);                                            // cycle 1: ISSUE
    checks++; if (ahbsram_req !== 1'b1) begin errors++; $display("FAIL sp_issue_req: got %b expected 1", ahbsram_req); end
    step(); spur = 1'b0; @(negedge HCLK);
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL sp_c2: got %b expected 0", m0_ack); end
    step(); @(negedge HCLK);
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL sp_c3: got %b expected 0", m0_ack); end
    step(); @(negedge HCLK);
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL sp_c4: got %b expected 0", m0_ack); end
    step(); @(negedge HCLK);
    checks++; if (m0_ack !== 1'b1 || m0_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL sp_c5: got ack %b rdata %h expected 1 0badf00d", m0_ack, m0_rdata); end
    step(); m0_req = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0; BUSY = 1'b0; spur = 1'b0; ctrl_delay = 0; ctrl_rdata = 32'h0;
    m0_req = 1'b0; m0_write = 1'b0; m0_size = 3'b000; m0_addr = '0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_write = 1'b0; m1_size = 3'b000; m1_addr = '0; m1_wdata = 32'h0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_busy();
    test_reset_mid_wait();
    test_cmd_hold();
    test_spurious_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
